regfile_2r1w_sb: RTL

Parametrised successor to the CPU's single-read register file, built for the pipelined RISC datapath. It provides DEPTH registers of WIDTH bits with two independent combinational read ports (A, B) and one synchronous write port. A write-through bypass lets a read see a same-cycle write. A per-register pending scoreboard lets decode stall on registers that still have an in-flight producer.

---
 rtl/regfile_2r1w_sb.sv | 112 +++++++++++
 1 files changed

// File: rtl/regfile_2r1w_sb.sv
// regfile_2r1w_sb: DEPTH x WIDTH register file with two combinational read
// ports, one synchronous write port, optional write-through bypass, optional
// hard-wired zero register, and a per-register pending scoreboard for decode.
module regfile_2r1w_sb #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 8,
  parameter bit          ZERO_R0 = 1'b0,
  parameter bit          BYPASS  = 1'b1,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [AW-1:0]    writenum,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    readnum_a,
  output logic [WIDTH-1:0] data_out_a,
  input  logic [AW-1:0]    readnum_b,
  output logic [WIDTH-1:0] data_out_b,
  input  logic             reserve,
  input  logic [AW-1:0]    reserve_num,
  output logic             busy_a,
  output logic             busy_b,
  output logic [DEPTH-1:0] pending
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  // Effective write/reserve enables after dropping index 0 when it is hard-wired.
  logic we_eff;
  logic rsv_eff;

  // Qualify write and reserve requests with the zero-register rule.
  always_comb begin
    we_eff  = write;
    rsv_eff = reserve;
    if (ZERO_R0 && (writenum == '0)) begin
      we_eff = 1'b0;
    end
    if (ZERO_R0 && (reserve_num == '0)) begin
      rsv_eff = 1'b0;
    end
  end

  // Next register contents: reset clears all, otherwise a single write commits.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_d[i] = '0;
      end
    end else if (we_eff) begin
      regs_d[writenum] = data_in;
    end
  end

  // Next scoreboard: reserve sets, write clears, reserve wins on collision.
  always_comb begin
    pending_d = pending_q;
    if (reset) begin
      pending_d = '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (rsv_eff && (reserve_num == AW'(i))) begin
          pending_d[i] = 1'b1;
        end else if (write && (writenum == AW'(i))) begin
          pending_d[i] = 1'b0;
        end
      end
    end
  end

  // State registers for storage and scoreboard.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      regs_q[i] <= regs_d[i];
    end
    pending_q <= pending_d;
  end

  assign pending = pending_q;

  // Combinational read ports: stored value, forwarded same-cycle write, zero register.
  always_comb begin
    data_out_a = regs_q[readnum_a];
    data_out_b = regs_q[readnum_b];
    busy_a     = pending_q[readnum_a];
    busy_b     = pending_q[readnum_b];
    if (BYPASS && write && (writenum == readnum_a)) begin
      data_out_a = data_in;
      busy_a     = 1'b0;
    end
    if (BYPASS && write && (writenum == readnum_b)) begin
      data_out_b = data_in;
      busy_b     = 1'b0;
    end
    if (ZERO_R0 && (readnum_a == '0)) begin
      data_out_a = '0;
      busy_a     = 1'b0;
    end
    if (ZERO_R0 && (readnum_b == '0)) begin
      data_out_b = '0;
      busy_b     = 1'b0;
    end
  end

endmodule
